fluxo_dados_seq_param: RTL and testbench

Parametrised successor to the fixed 4-key memory-game datapath. Adds a writable sequence memory (record new plays), a round-limit counter for growing sequences, a key-capture state machine that rejects multi-key presses, and a sticky timeout of configurable length. Sits under the game control unit, which drives every zera/conta/registra/escreve strobe and consumes the status flags.

---
 rtl/fluxo_dados_seq_param_pkg.sv | 18 +
 rtl/fluxo_dados_seq_param_if.sv | 46 ++++
 rtl/fluxo_dados_seq_param_captura_tecla.sv | 62 ++++++
 rtl/fluxo_dados_seq_param.sv | 121 ++++++++++++
 tb/tb_fluxo_dados_seq_param.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fluxo_dados_seq_param_pkg.sv
// Shared types and helpers for the memory-game datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fluxo_dados_seq_param_pkg;

  // Key-capture state codes; the numeric values are visible on db_estado_tecla.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    VALIDA   = 2'd1,
    INVALIDA = 2'd2
  } estado_tecla_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fluxo_dados_seq_param_if.sv
// Bundle of control strobes and status flags between the game control unit and the datapath.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is acted on in the cycle it is high.
interface fluxo_dados_seq_param_if #(
  parameter int KEY_W  = 4,
  parameter int ADDR_W = 4
);
  logic [KEY_W-1:0]  chaves;
  logic              zeraE;
  logic              contaE;
  logic              zeraL;
  logic              contaL;
  logic              zeraR;
  logic              registraR;
  logic              escreveM;
  logic              zeraT;
  logic              contaT;

  logic              igual;
  logic              enderecoIgualLimite;
  logic              fimE;
  logic              fimL;
  logic              jogada_feita;
  logic              jogada_invalida;
  logic              timeout;
  logic              db_tem_jogada;
  logic [ADDR_W-1:0] db_contagem;
  logic [ADDR_W-1:0] db_limite;
  logic [KEY_W-1:0]  db_memoria;
  logic [KEY_W-1:0]  db_jogada;
  logic [1:0]        db_estado_tecla;

  // Control unit side: drives keys and strobes, watches status.
  modport master (
    output chaves, zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, zeraT, contaT,
    input  igual, enderecoIgualLimite, fimE, fimL, jogada_feita, jogada_invalida, timeout,
           db_tem_jogada, db_contagem, db_limite, db_memoria, db_jogada, db_estado_tecla
  );

  // Datapath side.
  modport slave (
    input  chaves, zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, zeraT, contaT,
    output igual, enderecoIgualLimite, fimE, fimL, jogada_feita, jogada_invalida, timeout,
           db_tem_jogada, db_contagem, db_limite, db_memoria, db_jogada, db_estado_tecla
  );
endinterface

// File: rtl/fluxo_dados_seq_param_captura_tecla.sv
// Key-capture FSM: classifies a new press as one-hot (valid) or multi-key (invalid).
// Latency: pulse appears one cycle after the press is sampled, lasts exactly one cycle.
// Backpressure: none; a held press is ignored until all keys are released.
module fluxo_dados_seq_param_captura_tecla
  import fluxo_dados_seq_param_pkg::*;
#(
  parameter int KEY_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] chaves_i,
  output logic             feita_o,
  output logic             invalida_o,
  output estado_tecla_t    estado_o
);

  estado_tecla_t estado_q, estado_d;
  logic          feita_q, feita_d;
  logic          invalida_q, invalida_d;

  // State and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      estado_q   <= OCIOSO;
      feita_q    <= 1'b0;
      invalida_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      feita_q    <= feita_d;
      invalida_q <= invalida_d;
    end
  end

  // Only the first sample of a press (from idle) can produce a pulse.
  always_comb begin
    estado_d   = estado_q;
    feita_d    = 1'b0;
    invalida_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (chaves_i != '0) begin
          if ($onehot(chaves_i)) begin
            estado_d = VALIDA;
            feita_d  = 1'b1;
          end else begin
            estado_d   = INVALIDA;
            invalida_d = 1'b1;
          end
        end
      end
      VALIDA, INVALIDA: begin
        if (chaves_i == '0) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign feita_o    = feita_q;
  assign invalida_o = invalida_q;
  assign estado_o   = estado_q;

endmodule

// File: rtl/fluxo_dados_seq_param.sv
// Memory-game datapath: address/limit counters, play register, sequence RAM, key capture, timeout.
// Latency: RAM read 1 cycle; key pulses 1 cycle after press; flags combinational from registers.
// Backpressure: none; strobes from the control unit are applied every cycle they are high.
module fluxo_dados_seq_param
  import fluxo_dados_seq_param_pkg::*;
#(
  parameter int KEY_W       = 4,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 3000
) (
  input logic                  clock,
  input logic                  reset,
  fluxo_dados_seq_param_if.slave bus
);

  localparam int              DEPTH  = 2 ** ADDR_W;
  localparam int              TW     = cnt_width(TIMEOUT_CYC);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [KEY_W-1:0]  jogada_q, jogada_d;
  logic [KEY_W-1:0]  rdata_q;
  logic [KEY_W-1:0]  mem_q [DEPTH];
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              tout_q, tout_d;
  logic              t_en;
  estado_tecla_t     estado;
  logic              feita;
  logic              invalida;

  // Next-state for counters and play register; clear always beats count/load.
  always_comb begin
    endereco_d = endereco_q;
    limite_d   = limite_q;
    jogada_d   = jogada_q;
    if (bus.zeraE)       endereco_d = '0;
    else if (bus.contaE) endereco_d = endereco_q + 1'b1;
    if (bus.zeraL)       limite_d = '0;
    else if (bus.contaL) limite_d = limite_q + 1'b1;
    if (bus.zeraR)          jogada_d = '0;
    else if (bus.registraR) jogada_d = bus.chaves;
  end

  // Counter and play registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco_q <= '0;
      limite_q   <= '0;
      jogada_q   <= '0;
    end else begin
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      jogada_q   <= jogada_d;
    end
  end

  // RAM array write; contents deliberately survive reset so a sequence is not lost.
  always_ff @(posedge clock) begin
    if (bus.escreveM) mem_q[endereco_q] <= jogada_q;
  end

  // Registered read port; a same-cycle write to this address is seen next read (old data now).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= mem_q[endereco_q];
  end

  fluxo_dados_seq_param_captura_tecla #(
    .KEY_W (KEY_W)
  ) u_captura (
    .clk_i      (clock),
    .rst_ni     (reset),
    .chaves_i   (bus.chaves),
    .feita_o    (feita),
    .invalida_o (invalida),
    .estado_o   (estado)
  );

  // Idle time only accrues while nothing is pressed and the capture FSM is idle.
  assign t_en = bus.contaT && (estado == OCIOSO) && (bus.chaves == '0);

  // Timeout next-state: counter saturates at its last value and the flag latches.
  always_comb begin
    tcnt_d = tcnt_q;
    tout_d = tout_q;
    if (bus.zeraT) begin
      tcnt_d = '0;
      tout_d = 1'b0;
    end else if (t_en) begin
      if (tcnt_q == T_LAST) tout_d = 1'b1;
      else                  tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Timeout registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
    end
  end

  assign bus.igual               = (rdata_q == jogada_q);
  assign bus.enderecoIgualLimite = (endereco_q == limite_q);
  assign bus.fimE                = &endereco_q;
  assign bus.fimL                = &limite_q;
  assign bus.jogada_feita        = feita;
  assign bus.jogada_invalida     = invalida;
  assign bus.timeout             = tout_q;
  assign bus.db_tem_jogada       = |bus.chaves;
  assign bus.db_contagem         = endereco_q;
  assign bus.db_limite           = limite_q;
  assign bus.db_memoria          = rdata_q;
  assign bus.db_jogada           = jogada_q;
  assign bus.db_estado_tecla     = estado;

endmodule

// File: tb/tb_fluxo_dados_seq_param.sv
// Bench for the memory-game datapath: directed scenarios then randomized control traffic.
// Latency: reference model advances once per rising edge; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_fluxo_dados_seq_param;
  localparam int KW    = 4;
  localparam int AW    = 4;
  localparam int TO    = 10;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fluxo_dados_seq_param_if #(.KEY_W(KW), .ADDR_W(AW)) bus ();

  fluxo_dados_seq_param #(.KEY_W(KW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: game-level view (which address, which limit, what is stored,
  // whether a press is in progress, how many idle cycles since the last timeout clear).
  int        m_end, m_lim, m_key, m_idle;
  logic [3:0] m_jog, m_rd;
  bit        m_rd_ok, m_feita, m_inval;
  logic [3:0] m_mem [DEPTH];
  bit        m_ok [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_strobes();
    bus.zeraE = 0; bus.contaE = 0; bus.zeraL = 0; bus.contaL = 0;
    bus.zeraR = 0; bus.registraR = 0; bus.escreveM = 0;
    bus.zeraT = 0; bus.contaT = 0;
  endtask

  task automatic model_reset();
    m_end = 0; m_lim = 0; m_key = 0; m_idle = 0;
    m_jog = 0; m_rd = 0; m_rd_ok = 1; m_feita = 0; m_inval = 0;
  endtask

  task automatic model_update();
    int ones;
    bit idle_cnt;
    logic [3:0] c;
    if (!rst_n) return;
    c = bus.chaves;
    ones = $countones(c);
    idle_cnt = bus.contaT && (m_key == 0) && (c == 0);
    m_rd_ok = m_ok[m_end];
    m_rd    = m_mem[m_end];
    if (bus.escreveM) begin
      m_mem[m_end] = m_jog;
      m_ok[m_end]  = 1;
    end
    m_feita = (m_key == 0) && (ones == 1);
    m_inval = (m_key == 0) && (ones > 1);
    if (m_key == 0) m_key = (ones == 0) ? 0 : (ones == 1) ? 1 : 2;
    else if (c == 0) m_key = 0;
    if (bus.zeraT) m_idle = 0;
    else if (idle_cnt) m_idle++;
    if (bus.zeraR) m_jog = 0;
    else if (bus.registraR) m_jog = c;
    if (bus.zeraE) m_end = 0;
    else if (bus.contaE) m_end = (m_end + 1) % DEPTH;
    if (bus.zeraL) m_lim = 0;
    else if (bus.contaL) m_lim = (m_lim + 1) % DEPTH;
  endtask

  task automatic check_all();
    chk("contagem", 32'(bus.db_contagem), m_end);
    chk("limite", 32'(bus.db_limite), m_lim);
    chk("jogada", 32'(bus.db_jogada), 32'(m_jog));
    chk("estado", 32'(bus.db_estado_tecla), m_key);
    chk("feita", 32'(bus.jogada_feita), 32'(m_feita));
    chk("invalida", 32'(bus.jogada_invalida), 32'(m_inval));
    chk("timeout", 32'(bus.timeout), 32'(m_idle >= TO));
    chk("end_eq_lim", 32'(bus.enderecoIgualLimite), 32'(m_end == m_lim));
    chk("fimE", 32'(bus.fimE), 32'(m_end == DEPTH - 1));
    chk("fimL", 32'(bus.fimL), 32'(m_lim == DEPTH - 1));
    chk("tem_jogada", 32'(bus.db_tem_jogada), 32'(bus.chaves != 0));
    if (m_rd_ok) begin
      chk("memoria", 32'(bus.db_memoria), 32'(m_rd));
      chk("igual", 32'(bus.igual), 32'(m_rd == m_jog));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset pulse landing between edges; state must clear without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_contagem", 32'(bus.db_contagem), 0);
    chk("rst_limite", 32'(bus.db_limite), 0);
    chk("rst_jogada", 32'(bus.db_jogada), 0);
    chk("rst_estado", 32'(bus.db_estado_tecla), 0);
    chk("rst_feita", 32'(bus.jogada_feita), 0);
    chk("rst_invalida", 32'(bus.jogada_invalida), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_memoria", 32'(bus.db_memoria), 0);
    chk("rst_fimE", 32'(bus.fimE), 0);
    chk("rst_fimL", 32'(bus.fimL), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] rand_keys(input logic [3:0] prev);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return prev;
    if (r < 7) return 4'b0000;
    if (r < 9) return 4'(1 << $urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) m_ok[i] = 0;
    bus.chaves = '0;
    clr_strobes();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    async_reset();
    check_all();

    // Valid one-hot press held 5 cycles.
    bus.chaves = 4'b0001;
    tick();
    chk("d1_feita", 32'(bus.jogada_feita), 1);
    chk("d1_estado", 32'(bus.db_estado_tecla), 1);
    ticks(4);
    chk("d1_feita_once", 32'(bus.jogada_feita), 0);
    bus.chaves = 4'b0000;
    tick();
    chk("d1_estado_back", 32'(bus.db_estado_tecla), 0);

    // Multi-key press, then a valid one.
    bus.chaves = 4'b0101;
    tick();
    chk("d2_invalida", 32'(bus.jogada_invalida), 1);
    chk("d2_estado", 32'(bus.db_estado_tecla), 2);
    bus.chaves = 4'b0111;
    tick();
    chk("d2_invalida_once", 32'(bus.jogada_invalida), 0);
    bus.chaves = 4'b0000;
    tick();
    bus.chaves = 4'b0010;
    tick();
    chk("d2_feita", 32'(bus.jogada_feita), 1);
    bus.chaves = 4'b0000;
    tick();

    // Record 0100 at address 3, then read it back.
    bus.chaves = 4'b0100; bus.registraR = 1; bus.zeraE = 1;
    tick();
    bus.chaves = 4'b0000; bus.registraR = 0; bus.zeraE = 0; bus.contaE = 1;
    ticks(3);
    bus.contaE = 0; bus.escreveM = 1;
    tick();
    bus.escreveM = 0; bus.zeraE = 1;
    tick();
    bus.zeraE = 0; bus.contaE = 1;
    ticks(3);
    bus.contaE = 0;
    tick();
    chk("d3_memoria", 32'(bus.db_memoria), 32'h4);
    chk("d3_igual", 32'(bus.igual), 1);
    bus.chaves = 4'b1000; bus.registraR = 1;
    tick();
    bus.chaves = 4'b0000; bus.registraR = 0;
    chk("d3_igual_off", 32'(bus.igual), 0);
    tick();

    // Limit compare, end-of-sequence flag and wrap.
    bus.zeraE = 1; bus.zeraL = 1;
    tick();
    bus.zeraE = 0; bus.zeraL = 0; bus.contaL = 1;
    ticks(2);
    bus.contaL = 0; bus.contaE = 1;
    ticks(2);
    bus.contaE = 0;
    tick();
    chk("d4_eq_lim", 32'(bus.enderecoIgualLimite), 1);
    bus.contaE = 1;
    ticks(13);
    chk("d4_fimE", 32'(bus.fimE), 1);
    tick();
    chk("d4_wrap", 32'(bus.db_contagem), 0);
    bus.contaE = 0;

    // Timeout: ten idle cycles, sticky through a press, cleared by zeraT.
    bus.zeraT = 1;
    tick();
    bus.zeraT = 0; bus.contaT = 1;
    ticks(9);
    chk("d5_not_yet", 32'(bus.timeout), 0);
    tick();
    chk("d5_timeout", 32'(bus.timeout), 1);
    bus.chaves = 4'b0001;
    ticks(2);
    chk("d5_sticky", 32'(bus.timeout), 1);
    bus.chaves = 4'b0000; bus.zeraT = 1;
    tick();
    chk("d5_cleared", 32'(bus.timeout), 0);
    bus.zeraT = 0;
    ticks(5);
    bus.chaves = 4'b0010;
    ticks(4);
    bus.chaves = 4'b0000;
    ticks(5);
    chk("d5_paused", 32'(bus.timeout), 0);
    ticks(2);

    // Reset mid-count and mid-press; stored word must survive.
    bus.chaves = 4'b0001;
    tick();
    async_reset();
    bus.chaves = 4'b0000; bus.contaT = 0; bus.contaE = 1;
    ticks(3);
    bus.contaE = 0;
    tick();
    chk("d6_mem_kept", 32'(bus.db_memoria), 32'h4);

    // Randomized control traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.chaves    = rand_keys(bus.chaves);
      bus.zeraE     = ($urandom_range(0, 15) == 0);
      bus.contaE    = ($urandom_range(0, 2) == 0);
      bus.zeraL     = ($urandom_range(0, 19) == 0);
      bus.contaL    = ($urandom_range(0, 5) == 0);
      bus.zeraR     = ($urandom_range(0, 15) == 0);
      bus.registraR = ($urandom_range(0, 4) == 0);
      bus.escreveM  = ($urandom_range(0, 4) == 0);
      bus.zeraT     = ($urandom_range(0, 39) == 0);
      bus.contaT    = ($urandom_range(0, 3) != 0);
      if ((c % 200) >= 150) bus.chaves = 4'b0000;
      if ($urandom_range(0, 499) == 0) async_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
